bandgap_ctrl: RTL and testbench

- Shares the on-chip BANDGAP reference between NREQ requesters, driving the primitive's BGEN pin.
- Enables the bandgap on first demand and waits a settle time before granting.
- Keeps it on through a hold-off window after the last release, then powers it down.
- Sits between the user logic that needs the bandgap and the BANDGAP primitive instance; clocked from the oscillator-derived system clock.

---
 rtl/bandgap_ctrl.sv | 121 ++++++++++++
 tb/tb_bandgap_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bandgap_ctrl.sv
// rtl/bandgap_ctrl.sv - shared BANDGAP enable/settle/hold-off controller for NREQ requesters
// Optional build macro BG_FORCE_EN adds a force_on input that keeps the bandgap up without granting.
module bandgap_ctrl #(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 256,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
`ifdef BG_FORCE_EN
    input  logic            force_on,
`endif
    output logic [NREQ-1:0] ack,
    output logic            bgen,
    output logic            ready,
    output logic [1:0]      state_o,
    output logic [15:0]     enable_count
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_SETTLING = 2'd1,
        ST_ON       = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [NREQ-1:0]  req_q;
    logic             enable_inc;
    logic             any;

`ifdef BG_FORCE_EN
    logic force_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            force_q <= 1'b0;
        end else begin
            force_q <= force_on;
        end
    end

    assign any = (|req_q) | force_q;
`else
    assign any = |req_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_OFF;
            cnt          <= '0;
            req_q        <= '0;
            enable_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            req_q <= req;
            if (enable_inc && (enable_count != 16'hFFFF)) begin
                enable_count <= enable_count + 16'd1;
            end
        end
    end

    // A dropped demand always beats an expiring counter while settling, and a
    // returning demand always beats an expiring counter during hold-off.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enable_inc = 1'b0;
        case (state)
            ST_OFF: begin
                if (any) begin
                    state_next = ST_SETTLING;
                    cnt_next   = SETTLE_LOAD;
                    enable_inc = 1'b1;
                end
            end
            ST_SETTLING: begin
                if (!any) begin
                    state_next = ST_OFF;
                end else if (cnt == '0) begin
                    state_next = ST_ON;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_ON: begin
                if (!any) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (any) begin
                    state_next = ST_ON;
                end else if (cnt == '0) begin
                    state_next = ST_OFF;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    assign bgen    = (state != ST_OFF);
    assign ready   = (state == ST_ON) || (state == ST_HOLD);
    assign ack     = (state == ST_ON) ? req_q : '0;
    assign state_o = state;

endmodule

// File: tb/tb_bandgap_ctrl.sv
// tb/tb_bandgap_ctrl.sv - scoreboard bench for bandgap_ctrl with SETTLE_CYCLES=8, HOLD_CYCLES=4
module tb_bandgap_ctrl;

    localparam int S = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [3:0]  ack;
    logic        bgen;
    logic        ready;
    logic [1:0]  state_o;
    logic [15:0] enable_count;
`ifdef BG_FORCE_EN
    logic        force_on = 1'b0;
`endif

    typedef struct {
        logic [1:0]  st;
        logic [3:0]  ack;
        logic [15:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_step  = 0;

    always #5 clk = ~clk;

    bandgap_ctrl #(
        .NREQ(4), .SETTLE_CYCLES(S), .HOLD_CYCLES(H), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
`ifdef BG_FORCE_EN
        .force_on(force_on),
`endif
        .ack(ack),
        .bgen(bgen),
        .ready(ready),
        .state_o(state_o),
        .enable_count(enable_count)
    );

    task automatic check(input string name, input int idx, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, expv);
    endtask

    // Monitor: every falling edge, compare outputs against the expectation
    // pushed at the preceding rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int   eb;
            int   er;
            e  = exp_q.pop_front();
            eb = (e.st != 2'd0) ? 1 : 0;
            er = (e.st == 2'd2 || e.st == 2'd3) ? 1 : 0;
            check("state_o", n_step, int'(state_o), int'(e.st));
            check("bgen", n_step, int'(bgen), eb);
            check("ready", n_step, int'(ready), er);
            check("ack", n_step, int'(ack), int'(e.ack));
            check("enable_count", n_step, int'(enable_count), int'(e.ec));
            n_step++;
        end
    end

    // Apply inputs, take one rising edge, and record the outputs expected after it.
    task automatic step(input logic r, input logic [3:0] rq, input logic [1:0] st,
                        input logic [3:0] a, input logic [15:0] ec);
        exp_t e;
        rst = r;
        req = rq;
        @(posedge clk);
        e.st  = st;
        e.ack = a;
        e.ec  = ec;
        exp_q.push_back(e);
        #1;
    endtask

    // From OFF: capture edge, S settling edges, then ON with grant.
    task automatic acquire(input logic [3:0] rq, input logic [15:0] ec);
        step(1'b0, rq, 2'd0, 4'd0, ec - 16'd1);
        for (int i = 0; i < S; i++) step(1'b0, rq, 2'd1, 4'd0, ec);
        step(1'b0, rq, 2'd2, rq, ec);
    endtask

    // From ON: drop all, one ON edge with req_q cleared, H hold edges, then OFF.
    task automatic release_all(input logic [15:0] ec);
        step(1'b0, 4'd0, 2'd2, 4'd0, ec);
        for (int i = 0; i < H; i++) step(1'b0, 4'd0, 2'd3, 4'd0, ec);
        step(1'b0, 4'd0, 2'd0, 4'd0, ec);
    endtask

    initial begin
        #1;
        // reset and idle
        for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 2'd0, 4'd0, 16'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 2'd0, 4'd0, 16'd0);

        // basic grant
        acquire(4'b0001, 16'd1);

        // share, then release through hold-off
        step(1'b0, 4'b0101, 2'd2, 4'b0101, 16'd1);
        step(1'b0, 4'b0101, 2'd2, 4'b0101, 16'd1);
        release_all(16'd1);

        // hold re-acquire 2 cycles into HOLD
        acquire(4'b0010, 16'd2);
        step(1'b0, 4'd0, 2'd2, 4'd0, 16'd2);
        step(1'b0, 4'd0, 2'd3, 4'd0, 16'd2);
        step(1'b0, 4'd0, 2'd3, 4'd0, 16'd2);
        step(1'b0, 4'b0010, 2'd3, 4'd0, 16'd2);
        step(1'b0, 4'b0010, 2'd2, 4'b0010, 16'd2);
        step(1'b0, 4'b0010, 2'd2, 4'b0010, 16'd2);

        // request returns on the edge HOLD's counter reaches zero
        step(1'b0, 4'd0, 2'd2, 4'd0, 16'd2);
        for (int i = 0; i < H - 1; i++) step(1'b0, 4'd0, 2'd3, 4'd0, 16'd2);
        step(1'b0, 4'b0100, 2'd3, 4'd0, 16'd2);
        step(1'b0, 4'b0100, 2'd2, 4'b0100, 16'd2);
        release_all(16'd2);

        // abort 3 cycles into SETTLING
        step(1'b0, 4'b0001, 2'd0, 4'd0, 16'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 2'd1, 4'd0, 16'd3);
        step(1'b0, 4'd0, 2'd1, 4'd0, 16'd3);
        step(1'b0, 4'd0, 2'd0, 4'd0, 16'd3);
        step(1'b0, 4'd0, 2'd0, 4'd0, 16'd3);

        // drop coincides with settle counter at zero: abort wins
        step(1'b0, 4'b0001, 2'd0, 4'd0, 16'd3);
        for (int i = 0; i < S - 1; i++) step(1'b0, 4'b0001, 2'd1, 4'd0, 16'd4);
        step(1'b0, 4'd0, 2'd1, 4'd0, 16'd4);
        step(1'b0, 4'd0, 2'd0, 4'd0, 16'd4);

        // reset while ON
        acquire(4'b1000, 16'd5);
        step(1'b1, 4'b1000, 2'd0, 4'd0, 16'd0);
        step(1'b0, 4'b1000, 2'd0, 4'd0, 16'd0);
        step(1'b0, 4'b1000, 2'd1, 4'd0, 16'd1);
        step(1'b0, 4'd0, 2'd1, 4'd0, 16'd1);
        step(1'b0, 4'd0, 2'd0, 4'd0, 16'd1);

        repeat (3) @(posedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
